// File: rtl/tile_block_mem_if.sv
// Handshake bundle between the loader DMA / FFT input stage (master) and the
// complex-tile block memory (slave): a beat-wise write channel and a tile read channel.
interface tile_block_mem_if #(
    parameter int TILE       = 4,
    parameter int WR_ROWS    = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_W     = 32
);
    localparam int BEAT_W = WR_ROWS * TILE * 2 * DATA_W;
    localparam int TILE_W = TILE * TILE * 2 * DATA_W;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BEAT_W-1:0]     wr_data;
    logic                  wr_tile_done;

    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [TILE_W-1:0]     rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req_valid, rd_addr, rd_ready,
        input  wr_ready, wr_tile_done, rd_req_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req_valid, rd_addr, rd_ready,
        output wr_ready, wr_tile_done, rd_req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/tile_block_mem.sv
// Complex-tile store: tiles written as WR_ROWS-row beats into TILE/WR_ROWS banks, read whole.
// Optional macro TILE_MEM_BYPASS_EN makes same-address read/write collisions write-first.
module tile_block_mem #(
    parameter int TILE       = 4,
    parameter int WR_ROWS    = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    tile_block_mem_if.slave  m
);
    localparam int NB     = TILE / WR_ROWS;
    localparam int BEAT_W = WR_ROWS * TILE * 2 * DATA_W;
    localparam int TILE_W = TILE * TILE * 2 * DATA_W;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;

    logic [BEAT_W-1:0]     mem [NB][DEPTH];
    logic [CNT_W-1:0]      beat_cnt;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] wr_tgt_addr;
    logic                  wr_fire;
    logic                  last_beat;
    logic                  wr_tile_done_q;
    logic                  rd_fire;
    logic                  rd_valid_q;
    logic [TILE_W-1:0]     rd_data_q;
    logic [TILE_W-1:0]     rd_tile;
    logic [NB-1:0]         fwd;

    assign m.wr_ready     = rst_n;
    assign m.rd_req_ready = rst_n && (!rd_valid_q || m.rd_ready);
    assign m.wr_tile_done = wr_tile_done_q;
    assign m.rd_valid     = rd_valid_q;
    assign m.rd_data      = rd_data_q;

    assign wr_fire     = m.wr_valid && m.wr_ready;
    assign rd_fire     = m.rd_req_valid && m.rd_req_ready;
    assign last_beat   = (beat_cnt == CNT_W'(NB - 1));
    // Only the first beat of a tile takes its address from the bus.
    assign wr_tgt_addr = (beat_cnt == '0) ? m.wr_addr : wr_addr_q;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[beat_cnt][wr_tgt_addr] <= m.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt       <= '0;
            wr_addr_q      <= '0;
            wr_tile_done_q <= 1'b0;
        end else begin
            wr_tile_done_q <= wr_fire && last_beat;
            if (wr_fire) begin
                if (beat_cnt == '0) begin
                    wr_addr_q <= m.wr_addr;
                end
                beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
`ifdef TILE_MEM_BYPASS_EN
        assign fwd[b] = wr_fire && (wr_tgt_addr == m.rd_addr) && (beat_cnt == CNT_W'(b));
`else
        assign fwd[b] = 1'b0;
`endif
        // Without forwarding the array read sees pre-write contents (read-first).
        assign rd_tile[b*BEAT_W +: BEAT_W] = fwd[b] ? m.wr_data : mem[b][m.rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (rd_fire) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_tile;
        end else if (m.rd_ready) begin
            rd_valid_q <= 1'b0;
        end
    end
endmodule
